bp_me_wb_arbiter: RTL and testbench

Round-robin Wishbone B4 classic-cycle arbiter that lets `num_masters_p` Wishbone initiators share one Wishbone target. Typical use is several `bp_me_wb_master` adapters, e.g. per-core uncached ports, driving a single `bp_me_wb_client` or peripheral. The arbiter holds a grant for an entire `cyc` bus cycle. A watchdog converts a hung target into a Wishbone `err` to the owning master so that other masters are not starved.

---
 rtl/bp_me_wb_pkg.sv | 17 +
 rtl/bp_me_wb_rr_picker.sv | 28 ++
 rtl/bp_me_wb_arbiter.sv | 139 +++++++++++++
 tb/tb_bp_me_wb_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_me_wb_pkg.sv
// Shared Wishbone definitions for the bp_me_wb blocks: arbiter state encoding
// and width helper macros.
`ifndef BP_ME_WB_DEFINES_SVH
`define BP_ME_WB_DEFINES_SVH
`define BP_ME_WB_SEL_WIDTH(data_width_mp) ((data_width_mp)/8)
`define BP_ME_WB_WORD_ADR_WIDTH(paddr_width_mp, data_width_mp) ((paddr_width_mp) - $clog2((data_width_mp)/8))
`endif

package bp_me_wb_pkg;

  typedef enum logic [1:0] {
    e_idle  = 2'd0,
    e_busy  = 2'd1,
    e_abort = 2'd2
  } bp_me_wb_arb_state_e;

endpackage

// File: rtl/bp_me_wb_rr_picker.sv
// Combinational round-robin picker: grants the first requester found scanning
// upward from last_i+1, wrapping modulo num_reqs_p.
module bp_me_wb_rr_picker
#(parameter int num_reqs_p   = 2
 ,parameter int idx_width_lp = (num_reqs_p > 1) ? $clog2(num_reqs_p) : 1
 )
 (input  logic [num_reqs_p-1:0]   reqs_i
 ,input  logic [idx_width_lp-1:0] last_i
 ,output logic [num_reqs_p-1:0]   grant_o
 ,output logic                    v_o
 );

   int cand;

   always_comb begin
      grant_o = '0;
      v_o     = 1'b0;
      cand    = 0;
      for (int i = 1; i <= num_reqs_p; i++) begin
         cand = (int'(last_i) + i) % num_reqs_p;
         if (!v_o && reqs_i[cand]) begin
            grant_o[cand] = 1'b1;
            v_o           = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bp_me_wb_arbiter.sv
// Round-robin Wishbone B4 classic arbiter: holds a grant for a whole cyc and
// aborts the owner with err when the target stalls for timeout_p cycles.
module bp_me_wb_arbiter
   import bp_me_wb_pkg::*;
#(parameter int num_masters_p = 2
 ,parameter int data_width_p  = 64
 ,parameter int adr_width_p   = 37
 ,parameter int timeout_p     = 1024
 )
 (input  logic                                       clk_i
 ,input  logic                                       reset_n_i
 ,input  logic [num_masters_p*adr_width_p-1:0]       m_adr_i
 ,input  logic [num_masters_p*data_width_p-1:0]      m_dat_i
 ,input  logic [num_masters_p*(data_width_p/8)-1:0]  m_sel_i
 ,input  logic [num_masters_p-1:0]                   m_cyc_i
 ,input  logic [num_masters_p-1:0]                   m_stb_i
 ,input  logic [num_masters_p-1:0]                   m_we_i
 ,output logic [data_width_p-1:0]                    m_dat_o
 ,output logic [num_masters_p-1:0]                   m_ack_o
 ,output logic [num_masters_p-1:0]                   m_err_o
 ,output logic [adr_width_p-1:0]                     s_adr_o
 ,output logic [data_width_p-1:0]                    s_dat_o
 ,output logic [(data_width_p/8)-1:0]                s_sel_o
 ,output logic                                       s_cyc_o
 ,output logic                                       s_stb_o
 ,output logic                                       s_we_o
 ,input  logic [data_width_p-1:0]                    s_dat_i
 ,input  logic                                       s_ack_i
 ,output logic [num_masters_p-1:0]                   grant_o
 );

   localparam int sel_width_lp = data_width_p/8;
   localparam int idx_width_lp = (num_masters_p > 1) ? $clog2(num_masters_p) : 1;
   localparam int cnt_width_lp = (timeout_p > 0) ? $clog2(timeout_p+1) : 1;

   bp_me_wb_arb_state_e state_q, state_d;
   logic [num_masters_p-1:0] grant_q, grant_d;
   logic [idx_width_lp-1:0]  last_q, last_d;
   logic [cnt_width_lp-1:0]  wdog_q, wdog_d;

   logic [idx_width_lp-1:0]  owner, pick_last;
   logic [num_masters_p-1:0] pick_grant;
   logic                     pick_v, owner_cyc, owner_stb;

   always_comb begin
      owner = '0;
      for (int i = 0; i < num_masters_p; i++)
         if (grant_q[i]) owner = idx_width_lp'(i);
   end

   assign owner_cyc = m_cyc_i[owner];
   assign owner_stb = owner_cyc & m_stb_i[owner];
   // On release or abort exit the departing owner becomes the new pointer.
   assign pick_last = (state_q == e_idle) ? last_q : owner;

   bp_me_wb_rr_picker
    #(.num_reqs_p(num_masters_p), .idx_width_lp(idx_width_lp))
    picker
     (.reqs_i(m_cyc_i)
     ,.last_i(pick_last)
     ,.grant_o(pick_grant)
     ,.v_o(pick_v)
     );

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      wdog_d  = wdog_q;
      s_cyc_o = 1'b0;
      s_stb_o = 1'b0;
      s_we_o  = 1'b0;
      s_adr_o = '0;
      s_dat_o = '0;
      s_sel_o = '0;
      m_ack_o = '0;
      m_err_o = '0;
      case (state_q)
         e_idle: begin
            if (pick_v) begin
               state_d = e_busy;
               grant_d = pick_grant;
               wdog_d  = '0;
            end
         end
         e_busy, e_abort: begin
            if (state_q == e_busy) begin
               s_cyc_o = owner_cyc;
               s_stb_o = owner_stb;
               s_we_o  = m_we_i[owner];
               s_adr_o = m_adr_i[owner*adr_width_p +: adr_width_p];
               s_dat_o = m_dat_i[owner*data_width_p +: data_width_p];
               s_sel_o = m_sel_i[owner*sel_width_lp +: sel_width_lp];
            end
            if (!owner_cyc) begin
               last_d = owner;
               wdog_d = '0;
               if (pick_v) begin
                  state_d = e_busy;
                  grant_d = pick_grant;
               end else begin
                  state_d = e_idle;
                  grant_d = '0;
               end
            end else if (state_q == e_busy && owner_stb) begin
               if (s_ack_i) begin
                  m_ack_o = grant_q;
                  wdog_d  = '0;
               end else if (timeout_p != 0 && wdog_q == cnt_width_lp'(timeout_p-1)) begin
                  m_err_o = grant_q;
                  wdog_d  = '0;
                  state_d = e_abort;
               end else if (timeout_p != 0) begin
                  wdog_d  = wdog_q + 1'b1;
               end
            end
         end
         default: state_d = e_idle;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= e_idle;
         grant_q <= '0;
         last_q  <= idx_width_lp'(num_masters_p-1);
         wdog_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         wdog_q  <= wdog_d;
      end
   end

   assign grant_o = grant_q;
   assign m_dat_o = s_dat_i;

endmodule

// File: tb/tb_bp_me_wb_arbiter.sv
// Bench for bp_me_wb_arbiter: directed scenarios plus randomized masters and
// target, checked every cycle against an ownership-level reference model.
module tb_bp_me_wb_arbiter;

   localparam int NM = 2;
   localparam int DW = 64;
   localparam int AW = 37;
   localparam int SW = DW/8;
   localparam int T  = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [NM*AW-1:0] m_adr_i;
   logic [NM*DW-1:0] m_dat_i;
   logic [NM*SW-1:0] m_sel_i;
   logic [NM-1:0]    m_cyc_i, m_stb_i, m_we_i;
   logic [DW-1:0]    m_dat_o;
   logic [NM-1:0]    m_ack_o, m_err_o, grant_o;
   logic [AW-1:0]    s_adr_o;
   logic [DW-1:0]    s_dat_o, s_dat_i;
   logic [SW-1:0]    s_sel_o;
   logic             s_cyc_o, s_stb_o, s_we_o, s_ack_i;

   int checks = 0;
   int errors = 0;

   bp_me_wb_arbiter #(.num_masters_p(NM), .data_width_p(DW), .adr_width_p(AW), .timeout_p(T)) dut
     (.clk_i(clk), .reset_n_i(rst_n)
     ,.m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i)
     ,.m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i)
     ,.m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o)
     ,.s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o)
     ,.s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o)
     ,.s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .grant_o(grant_o)
     );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: who owns the bus, whether it is aborted, pointer, stall count.
   int m_owner = -1, m_last = NM-1, m_stall = 0;
   bit m_abort = 1'b0;
   int n_owner = -1, n_last = NM-1, n_stall = 0;
   bit n_abort = 1'b0;

   function automatic int rr_pick(input logic [NM-1:0] req, input int from);
      for (int i = 1; i <= NM; i++) begin
         int k;
         k = (from + i) % NM;
         if (req[k]) return k;
      end
      return -1;
   endfunction

   logic [NM-1:0] e_grant, e_ack, e_err;
   logic          e_cyc, e_stb, e_we;
   logic [AW-1:0] e_adr;
   logic [DW-1:0] e_dat;
   logic [SW-1:0] e_sel;

   initial forever begin
      @(negedge clk);
      e_grant = '0; e_ack = '0; e_err = '0;
      e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0;
      e_adr = '0; e_dat = '0; e_sel = '0;
      if (!rst_n) begin
         n_owner = -1; n_last = NM-1; n_stall = 0; n_abort = 1'b0;
      end else begin
         if (m_owner >= 0) e_grant[m_owner] = 1'b1;
         if (m_owner >= 0 && !m_abort) begin
            e_cyc = m_cyc_i[m_owner];
            e_stb = m_cyc_i[m_owner] & m_stb_i[m_owner];
            e_we  = m_we_i[m_owner];
            e_adr = m_adr_i[m_owner*AW +: AW];
            e_dat = m_dat_i[m_owner*DW +: DW];
            e_sel = m_sel_i[m_owner*SW +: SW];
            if (e_stb && s_ack_i) e_ack[m_owner] = 1'b1;
            if (e_stb && !s_ack_i && m_stall == T-1) e_err[m_owner] = 1'b1;
         end
         n_owner = m_owner; n_last = m_last; n_stall = m_stall; n_abort = m_abort;
         if (m_owner < 0) begin
            n_owner = rr_pick(m_cyc_i, m_last);
            n_stall = 0;
         end else if (!m_cyc_i[m_owner]) begin
            n_last  = m_owner;
            n_owner = rr_pick(m_cyc_i, m_owner);
            n_abort = 1'b0;
            n_stall = 0;
         end else if (!m_abort && e_stb) begin
            if (s_ack_i) n_stall = 0;
            else if (m_stall == T-1) begin n_abort = 1'b1; n_stall = 0; end
            else n_stall = m_stall + 1;
         end
      end
      check("grant", grant_o, e_grant);
      check("m_ack", m_ack_o, e_ack);
      check("m_err", m_err_o, e_err);
      check("s_cyc", s_cyc_o, e_cyc);
      check("s_stb", s_stb_o, e_stb);
      check("s_we", s_we_o, e_we);
      check("s_adr", s_adr_o, e_adr);
      check("s_dat", s_dat_o, e_dat);
      check("s_sel", s_sel_o, e_sel);
      check("m_dat", m_dat_o, s_dat_i);
   end

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_owner = -1; m_last = NM-1; m_stall = 0; m_abort = 1'b0;
      end else begin
         m_owner = n_owner; m_last = n_last; m_stall = n_stall; m_abort = n_abort;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; m_cyc_i = '0; m_stb_i = '0; s_ack_i = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
   endtask

   task automatic payload(input int k);
      m_adr_i[k*AW +: AW] = AW'({$urandom(), $urandom()});
      m_dat_i[k*DW +: DW] = {$urandom(), $urandom()};
      m_sel_i[k*SW +: SW] = SW'($urandom());
      m_we_i[k]           = 1'($urandom_range(0, 1));
   endtask

   // One acked beat from owner k, then k drops cyc for its release cycle.
   task automatic beat_and_drop(input int k);
      s_ack_i = 1'b1;
      tick();
      s_ack_i = 1'b0; m_cyc_i[k] = 1'b0; m_stb_i[k] = 1'b0;
      tick();
   endtask

   logic [63:0]   fdat [NM] = '{64'hA5A5_0000_1111_2222, 64'h5A5A_3333_4444_0000};
   logic [SW-1:0] fsel [NM] = '{8'h0F, 8'hF0};
   logic [NM-1:0] ack_s, err_s;
   int            beats [NM];
   bit            dead;

   initial begin
      rst_n = 1'b0; m_adr_i = '0; m_dat_i = '0; m_sel_i = '0;
      m_cyc_i = '0; m_stb_i = '0; m_we_i = '0; s_ack_i = 1'b0;
      s_dat_i = 64'h1234; dead = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_grant", grant_o, 0);
      check("rst_s_cyc", s_cyc_o, 0);
      check("rst_m_dat", m_dat_o, 64'h1234);
      tick(); rst_n = 1'b1;

      // single master read
      m_adr_i[0 +: AW] = AW'(64'h10); m_we_i[0] = 1'b0; m_sel_i[0 +: SW] = 8'hFF;
      m_cyc_i[0] = 1'b1; m_stb_i[0] = 1'b1;
      @(negedge clk); check("single_idle_cyc", s_cyc_o, 0);
      tick();
      @(negedge clk);
      check("single_cyc", s_cyc_o, 1);
      check("single_grant", grant_o, 2'b01);
      check("single_adr", s_adr_o, 64'h10);
      repeat (3) tick();
      s_ack_i = 1'b1; s_dat_i = 64'hDEAD_BEEF;
      @(negedge clk);
      check("single_ack", m_ack_o, 2'b01);
      check("single_dat", m_dat_o, 64'hDEAD_BEEF);
      tick(); s_ack_i = 1'b0; m_cyc_i[0] = 1'b0; m_stb_i[0] = 1'b0;
      @(negedge clk); check("single_ack_gone", m_ack_o, 0);
      tick();
      @(negedge clk); check("single_grant_idle", grant_o, 0);

      // contention, twice
      do_reset();
      for (int r = 0; r < 2; r++) begin
         payload(0); payload(1);
         m_cyc_i = 2'b11; m_stb_i = 2'b11;
         tick();
         @(negedge clk); check("cont_first", grant_o, 2'b01);
         beat_and_drop(0);
         @(negedge clk); check("cont_second", grant_o, 2'b10);
         beat_and_drop(1);
      end

      // fairness: both request continuously, 4 writes per ownership
      do_reset();
      for (int k = 0; k < NM; k++) begin
         m_dat_i[k*DW +: DW] = fdat[k]; m_sel_i[k*SW +: SW] = fsel[k];
         m_adr_i[k*AW +: AW] = AW'(64'h100 + k);
      end
      m_we_i = 2'b11; m_cyc_i = 2'b11; m_stb_i = 2'b11;
      tick();
      for (int r = 0; r < 4; r++) begin
         int g;
         g = r % 2;
         s_ack_i = 1'b1;
         @(negedge clk);
         check("fair_grant", grant_o, 64'd1 << g);
         check("fair_dat", s_dat_o, fdat[g]);
         check("fair_sel", s_sel_o, fsel[g]);
         check("fair_we", s_we_o, 1);
         for (int b = 0; b < 4; b++) begin
            if (b > 0) @(negedge clk);
            check("fair_ack", m_ack_o, 64'd1 << g);
            tick();
         end
         s_ack_i = 1'b0; m_cyc_i[g] = 1'b0; m_stb_i[g] = 1'b0;
         tick();
         m_cyc_i[g] = 1'b1; m_stb_i[g] = 1'b1;
      end
      m_cyc_i = '0; m_stb_i = '0;
      tick(); tick();

      // watchdog timeout with a dead target
      do_reset();
      payload(0); payload(1);
      m_cyc_i = 2'b11; m_stb_i = 2'b11;
      tick();
      for (int i = 0; i < T; i++) begin
         @(negedge clk);
         check("to_err", m_err_o, (i == T-1) ? 2'b01 : 2'b00);
         tick();
      end
      s_ack_i = 1'b1;
      @(negedge clk);
      check("to_abort_cyc", s_cyc_o, 0);
      check("to_late_ack", m_ack_o, 0);
      check("to_abort_grant", grant_o, 2'b01);
      tick(); m_cyc_i[0] = 1'b0; m_stb_i[0] = 1'b0;
      @(negedge clk); check("to_late_ack2", m_ack_o, 0);
      tick();
      @(negedge clk);
      check("to_next_grant", grant_o, 2'b10);
      check("to_next_ack", m_ack_o, 2'b10);
      tick(); s_ack_i = 1'b0; m_cyc_i[1] = 1'b0; m_stb_i[1] = 1'b0;
      tick();

      // reset mid-transfer, pointer must return to its reset value
      m_cyc_i[0] = 1'b1; m_stb_i[0] = 1'b1;
      tick();
      beat_and_drop(0);
      m_cyc_i[1] = 1'b1; m_stb_i[1] = 1'b1;
      tick();
      s_ack_i = 1'b1;
      #1 check("rstmid_ack_before", m_ack_o, 2'b10);
      #1 rst_n = 1'b0;
      #1;
      check("rstmid_grant", grant_o, 0);
      check("rstmid_cyc", s_cyc_o, 0);
      check("rstmid_ack", m_ack_o, 0);
      m_cyc_i = '0; m_stb_i = '0; s_ack_i = 1'b0;
      tick(); tick();
      m_cyc_i = 2'b11; m_stb_i = 2'b11; rst_n = 1'b1;
      tick();
      @(negedge clk); check("rstmid_ptr", grant_o, 2'b01);

      // multi-beat hold by master 1 while master 0 waits
      beat_and_drop(0);
      m_cyc_i[0] = 1'b1; m_stb_i[0] = 1'b1;
      for (int b = 0; b < 3; b++) begin
         s_ack_i = 1'b1;
         @(negedge clk); check("hold_ack", m_ack_o, 2'b10);
         tick(); s_ack_i = 1'b0; m_stb_i[1] = 1'b0;
         @(negedge clk); check("hold_grant", grant_o, 2'b10);
         tick(); m_stb_i[1] = 1'b1;
      end
      m_cyc_i[1] = 1'b0; m_stb_i[1] = 1'b0;
      @(negedge clk); check("hold_release", grant_o, 2'b10);
      tick();
      @(negedge clk); check("hold_next", grant_o, 2'b01);
      beat_and_drop(0);

      // randomized masters and target
      for (int k = 0; k < NM; k++) beats[k] = 0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk); ack_s = m_ack_o; err_s = m_err_o;
         tick();
         if (c == 1500) begin
            do_reset();
            for (int k = 0; k < NM; k++) beats[k] = 0;
            ack_s = '0; err_s = '0;
         end
         if ($urandom_range(0, 31) == 0) dead = ~dead;
         s_ack_i = dead ? 1'b0 : 1'($urandom_range(0, 9) < 4);
         s_dat_i = {$urandom(), $urandom()};
         for (int k = 0; k < NM; k++) begin
            if (m_cyc_i[k]) begin
               if (err_s[k]) begin
                  m_cyc_i[k] = 1'b0; m_stb_i[k] = 1'b0;
               end else if (ack_s[k]) begin
                  beats[k]--;
                  if (beats[k] <= 0) begin
                     m_cyc_i[k] = 1'b0; m_stb_i[k] = 1'b0;
                  end else begin
                     m_stb_i[k] = 1'($urandom_range(0, 1)); payload(k);
                  end
               end else if (!m_stb_i[k]) begin
                  m_stb_i[k] = 1'($urandom_range(0, 1));
                  if (m_stb_i[k]) payload(k);
               end
            end else if ($urandom_range(0, 3) == 0) begin
               m_cyc_i[k] = 1'b1; beats[k] = int'($urandom_range(1, 3));
               m_stb_i[k] = 1'($urandom_range(0, 1)); payload(k);
            end
         end
      end

      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
